l2_request_arbiter: RTL and testbench

- Sits between the L1 side and the unified L2 cache.
- Merges two requesters onto the single L2 port:
  - I-side: line reads from the hardware prefetcher controller, i.e. its l2_read path.
  - D-side: line reads and writebacks from the D-cache.
- Grants one requester at a time and holds the grant until L2 responds. Ties are broken by round-robin.
- Keeps saturating grant counters for performance analysis.

---
 rtl/l2_request_arbiter_pkg.sv | 29 ++
 rtl/l2_request_arbiter_sat_counter.sv | 26 ++
 rtl/l2_request_arbiter.sv | 115 +++++++++++
 tb/tb_l2_request_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_request_arbiter_pkg.sv
// Shared types for the L2 request arbiter: LC-3b word/line types, FSM states, grant side.
package l2_request_arbiter_pkg;

    localparam int unsigned LC3B_WORD_W = 16;
    localparam int unsigned LC3B_LINE_W = 128;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_cline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Round-robin pick: on a tie the side that did not win last time goes next.
    function automatic grant_t pick_grant(input logic i_req, input logic d_req, input grant_t last);
        if (i_req && d_req) begin
            return (last == GRANT_D) ? GRANT_I : GRANT_D;
        end
        return i_req ? GRANT_I : GRANT_D;
    endfunction

endpackage

// File: rtl/l2_request_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/l2_request_arbiter.sv
// Two-requester (I-side / D-side) arbiter onto a single L2 port, round-robin on ties,
// grant held until L2 responds, with saturating per-side completion counters.
module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read,
    input  lc3b_word          i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  lc3b_word          d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output lc3b_word          l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    input  logic              clr_counters,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    arb_state_t        r_state;
    grant_t            r_last;
    lc3b_word          r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_write;

    logic   w_d_req;
    logic   w_busy;
    logic   w_i_inc;
    logic   w_d_inc;
    grant_t w_grant;

    assign w_d_req = d_read | d_write;
    assign w_grant = pick_grant(i_read, w_d_req, r_last);

    // Grant is taken only from IDLE, so every transaction is followed by one IDLE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= GRANT_D;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_read || w_d_req) begin
                        r_last <= w_grant;
                        if (w_grant == GRANT_I) begin
                            r_state <= SERVE_I;
                            r_addr  <= i_address;
                            r_wdata <= '0;
                            r_write <= 1'b0;
                        end else begin
                            // Read+write together is illegal; the write wins.
                            r_state <= SERVE_D;
                            r_addr  <= d_address;
                            r_wdata <= d_wdata;
                            r_write <= d_write;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (l2_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // L2 command is a pure decode of registered state; it cannot be aborted by the requester.
    assign w_busy     = (r_state != IDLE);
    assign l2_read    = w_busy & ~r_write;
    assign l2_write   = w_busy & r_write;
    assign l2_address = r_addr;
    assign l2_wdata   = r_wdata;

    assign w_i_inc = (r_state == SERVE_I) & l2_resp;
    assign w_d_inc = (r_state == SERVE_D) & l2_resp;

    assign i_resp  = w_i_inc;
    assign d_resp  = w_d_inc;
    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;

    sat_counter #(.WIDTH(CNT_W)) u_i_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_i_inc),
        .clr     (clr_counters),
        .count   (i_grant_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_d_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (w_d_inc),
        .clr     (clr_counters),
        .count   (d_grant_cnt)
    );

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_l2_request_arbiter;

    localparam int unsigned LINE_W  = 128;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              reset_n;
    logic              i_read;
    logic [15:0]       i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [15:0]       d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              l2_read;
    logic              l2_write;
    logic [15:0]       l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic [LINE_W-1:0] l2_rdata;
    logic              l2_resp;
    logic              clr_counters;
    logic [CNT_W-1:0]  i_grant_cnt;
    logic [CNT_W-1:0]  d_grant_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which side owns L2 (0 none, 1 I, 2 D), who won last, captured request, counts.
    int           m_busy;
    bit           m_last_i;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    bit           m_write;
    int           m_cnt_i;
    int           m_cnt_d;

    l2_request_arbiter #(.LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .l2_read      (l2_read),
        .l2_write     (l2_write),
        .l2_address   (l2_address),
        .l2_wdata     (l2_wdata),
        .l2_rdata     (l2_rdata),
        .l2_resp      (l2_resp),
        .clr_counters (clr_counters),
        .i_grant_cnt  (i_grant_cnt),
        .d_grant_cnt  (d_grant_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_last_i = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_write  = 1'b0;
        m_cnt_i  = 0;
        m_cnt_d  = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_step();
        int side;
        bit dreq;
        if (!reset_n) return;
        if (m_busy != 0) begin
            if (l2_resp) begin
                if (m_busy == 1 && m_cnt_i < CNT_MAX) m_cnt_i++;
                if (m_busy == 2 && m_cnt_d < CNT_MAX) m_cnt_d++;
                m_busy = 0;
            end
        end else begin
            dreq = d_read || d_write;
            if (i_read && dreq) side = m_last_i ? 2 : 1;
            else if (i_read)    side = 1;
            else if (dreq)      side = 2;
            else                side = 0;
            if (side != 0) begin
                m_busy   = side;
                m_last_i = (side == 1);
                m_addr   = (side == 1) ? i_address : d_address;
                m_write  = (side == 2) && d_write;
                m_wdata  = (side == 2) ? d_wdata : '0;
            end
        end
        if (clr_counters) begin
            m_cnt_i = 0;
            m_cnt_d = 0;
        end
    endtask

    // Called at a negedge with inputs set: check all outputs, step model, move to next negedge.
    task automatic cyc();
        if (!reset_n) l2_rdata = '0;
        else if (!l2_resp) l2_rdata = rand_line();
        #1;
        if (!reset_n) model_reset();
        check_eq("l2_read",  128'(l2_read),  128'(m_busy != 0 && !m_write));
        check_eq("l2_write", 128'(l2_write), 128'(m_busy != 0 && m_write));
        if (m_busy != 0 || !reset_n) begin
            check_eq("l2_address", 128'(l2_address), 128'(m_addr));
            check_eq("l2_wdata",   l2_wdata,         m_wdata);
        end
        check_eq("i_resp",  128'(i_resp), 128'(m_busy == 1 && l2_resp && reset_n));
        check_eq("d_resp",  128'(d_resp), 128'(m_busy == 2 && l2_resp && reset_n));
        check_eq("i_rdata", i_rdata, l2_rdata);
        check_eq("d_rdata", d_rdata, l2_rdata);
        check_eq("i_grant_cnt", 128'(i_grant_cnt), 128'(m_cnt_i));
        check_eq("d_grant_cnt", 128'(d_grant_cnt), 128'(m_cnt_d));
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        i_read       = 1'b0;
        d_read       = 1'b0;
        d_write      = 1'b0;
        l2_resp      = 1'b0;
        clr_counters = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        l2_rdata  = '0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        cyc();
        cyc();
        reset_n = 1'b1;

        // I-only read of 0x1230, response with 0xAAAA.. after 3 serve cycles
        i_read = 1'b1; i_address = 16'h1230;
        cyc();
        check_eq("t1_read_cmd", 128'(l2_read), 128'(1));
        check_eq("t1_addr", 128'(l2_address), 128'(16'h1230));
        cyc();
        cyc();
        l2_resp = 1'b1; l2_rdata = {32{4'hA}};
        #1;
        check_eq("t1_i_resp", 128'(i_resp), 128'(1));
        check_eq("t1_d_resp", 128'(d_resp), 128'(0));
        check_eq("t1_i_rdata", i_rdata, {32{4'hA}});
        cyc();
        l2_resp = 1'b0; i_read = 1'b0;
        check_eq("t1_i_cnt", 128'(i_grant_cnt), 128'(1));
        cyc();

        // Simultaneous I read and D write straight after reset
        do_reset();
        i_read = 1'b1; i_address = 16'h0040;
        d_write = 1'b1; d_address = 16'h8000; d_wdata = {32{4'h5}};
        cyc();
        check_eq("t2_i_first", 128'(l2_address), 128'(16'h0040));
        cyc();
        l2_resp = 1'b1;
        cyc();
        l2_resp = 1'b0; i_read = 1'b0;
        cyc();
        check_eq("t2_write_cmd", 128'(l2_write), 128'(1));
        check_eq("t2_d_addr", 128'(l2_address), 128'(16'h8000));
        check_eq("t2_d_wdata", l2_wdata, {32{4'h5}});
        l2_resp = 1'b1;
        cyc();
        l2_resp = 1'b0; d_write = 1'b0;
        check_eq("t2_i_cnt", 128'(i_grant_cnt), 128'(1));
        check_eq("t2_d_cnt", 128'(d_grant_cnt), 128'(1));
        cyc();

        // Continuous requests from both sides alternate I, D, I, D, I, D
        do_reset();
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check_eq("t3_alt", 128'(l2_address), (k % 2 == 0) ? 128'(16'h1111) : 128'(16'h2222));
            repeat ($urandom_range(0, 2)) cyc();
            l2_resp = 1'b1;
            cyc();
            l2_resp = 1'b0;
        end
        i_read = 1'b0; d_read = 1'b0;
        check_eq("t3_i_cnt", 128'(i_grant_cnt), 128'(3));
        check_eq("t3_d_cnt", 128'(d_grant_cnt), 128'(3));
        cyc();

        // D address changes and d_read drops mid-transaction
        d_read = 1'b1; d_address = 16'h2000;
        cyc();
        d_address = 16'h3000; d_read = 1'b0;
        cyc();
        check_eq("t4_addr_hold", 128'(l2_address), 128'(16'h2000));
        cyc();
        l2_resp = 1'b1;
        #1;
        check_eq("t4_d_resp", 128'(d_resp), 128'(1));
        cyc();
        l2_resp = 1'b0;
        check_eq("t4_d_cnt", 128'(d_grant_cnt), 128'(4));

        // Reset during SERVE_D, then a tie goes to the I-side
        d_read = 1'b1; d_address = 16'h4444;
        cyc();
        d_read = 1'b0;
        cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        cyc();
        check_eq("t5_i_wins", 128'(l2_address), 128'(16'h1111));
        l2_resp = 1'b1;
        cyc();
        idle_inputs();
        cyc();

        // Saturate d_grant_cnt, then clear coincident with a completion
        d_read = 1'b1; d_address = 16'h0005;
        repeat (CNT_MAX + 3) begin
            cyc();
            l2_resp = 1'b1;
            cyc();
            l2_resp = 1'b0;
        end
        check_eq("t6_d_sat", 128'(d_grant_cnt), 128'(CNT_MAX));
        cyc();
        l2_resp = 1'b1;
        cyc();
        l2_resp = 1'b0;
        check_eq("t6_d_sat_hold", 128'(d_grant_cnt), 128'(CNT_MAX));
        cyc();
        l2_resp = 1'b1; clr_counters = 1'b1;
        cyc();
        idle_inputs();
        check_eq("t6_clr_i", 128'(i_grant_cnt), 128'(0));
        check_eq("t6_clr_d", 128'(d_grant_cnt), 128'(0));
        cyc();

        // Random traffic, including stray responses in IDLE, clears and resets
        repeat (800) begin
            reset_n      = ($urandom_range(0, 149) != 0);
            i_read       = ($urandom_range(0, 1) != 0);
            d_read       = ($urandom_range(0, 2) == 0);
            d_write      = ($urandom_range(0, 2) == 0);
            i_address    = 16'($urandom());
            d_address    = 16'($urandom());
            d_wdata      = rand_line();
            l2_resp      = ($urandom_range(0, 2) == 0);
            l2_rdata     = rand_line();
            clr_counters = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
